// File: rtl/syn_pkg.sv
//==============================================================================
// syn_pkg : sync/escape words and state type shared by framer and deframer.
// Revision : 1.0
//==============================================================================
`default_nettype none

package syn_pkg;

    localparam logic [23:0] SYNC_POS = 24'h7FFFFF;
    localparam logic [23:0] SYNC_NEG = 24'h800000;
    localparam logic [23:0] ESC_POS  = 24'h7FFFFE;
    localparam logic [23:0] ESC_NEG  = 24'h800001;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        SYNC1  = 2'd1,
        SYNC2  = 2'd2,
        LOCKED = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/syn_frame_timer.sv
//==============================================================================
// syn_frame_timer : counts emitted frames since the last header; flags timeout.
// Revision : 1.0
//==============================================================================
`default_nettype none

module syn_frame_timer #(
    parameter int MAX_FRAMES = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic tick,
    output logic expire
);

    localparam int CNT_W = $clog2(MAX_FRAMES + 1);
    localparam logic [CNT_W-1:0] LAST_FRAME = CNT_W'(MAX_FRAMES - 1);

    logic [CNT_W-1:0] frame_cnt;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            frame_cnt <= '0;
        end else if (tick) begin
            frame_cnt <= frame_cnt + CNT_W'(1);
        end
    end

    // Fires on the tick that completes the MAX_FRAMES-th frame.
    assign expire = tick && (frame_cnt == LAST_FRAME);

endmodule

`default_nettype wire

// File: rtl/syn_deframer.sv
//==============================================================================
// syn_deframer : hunts for the sync header and reassembles NUM_CH-word samples.
// Optional: define SYN_ERR_CNT_EN to add the saturating err_cnt output.
// Revision : 1.0
//==============================================================================
`default_nettype none

module syn_deframer
    import syn_pkg::*;
#(
    parameter int DATA_W     = 24,
    parameter int NUM_CH     = 8,
    parameter int MAX_FRAMES = 1024
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [DATA_W-1:0]        in_data,
    output logic [NUM_CH*DATA_W-1:0] out_data,
    output logic                     out_valid,
    output logic                     locked,
    output logic                     frame_err
`ifdef SYN_ERR_CNT_EN
    ,
    output logic [15:0]              err_cnt
`endif
);

    localparam int SC_W  = $clog2(NUM_CH + 1);
    localparam int IDX_W = $clog2(NUM_CH);
    localparam logic [SC_W-1:0]  LAST_SYNC = SC_W'(NUM_CH - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_CH - 1);

    state_t            state, state_n;
    logic [SC_W-1:0]   sync_cnt, sync_cnt_n;
    logic [IDX_W-1:0]  ch_idx, ch_idx_n;
    logic              relock, relock_n;
    logic              err_n;
    logic              emit;
    logic              store;
    logic              timer_clear;
    logic              expire;
    logic              is_pos;
    logic              is_neg;
    logic [(NUM_CH-1)*DATA_W-1:0] frame_buf;

    assign is_pos = (in_data == DATA_W'(SYNC_POS));
    assign is_neg = (in_data == DATA_W'(SYNC_NEG));

    always_comb begin
        state_n     = state;
        sync_cnt_n  = sync_cnt;
        ch_idx_n    = ch_idx;
        relock_n    = relock;
        err_n       = 1'b0;
        emit        = 1'b0;
        store       = 1'b0;
        timer_clear = 1'b0;
        if (in_valid) begin
            case (state)
                HUNT: begin
                    if (is_pos) begin
                        state_n    = SYNC1;
                        sync_cnt_n = SC_W'(1);
                    end
                end
                SYNC1: begin
                    if (is_pos) begin
                        if (sync_cnt == LAST_SYNC) begin
                            state_n    = SYNC2;
                            sync_cnt_n = '0;
                        end else begin
                            sync_cnt_n = sync_cnt + SC_W'(1);
                        end
                    end else begin
                        state_n    = HUNT;
                        sync_cnt_n = '0;
                        relock_n   = 1'b0;
                        err_n      = relock;
                    end
                end
                SYNC2: begin
                    if (is_neg) begin
                        if (sync_cnt == LAST_SYNC) begin
                            state_n     = LOCKED;
                            sync_cnt_n  = '0;
                            ch_idx_n    = '0;
                            relock_n    = 1'b0;
                            timer_clear = 1'b1;
                        end else begin
                            sync_cnt_n = sync_cnt + SC_W'(1);
                        end
                    end else if (is_pos) begin
                        state_n    = SYNC1;
                        sync_cnt_n = SC_W'(1);
                    end else begin
                        state_n    = HUNT;
                        sync_cnt_n = '0;
                        relock_n   = 1'b0;
                        err_n      = relock;
                    end
                end
                LOCKED: begin
                    if (is_neg || (is_pos && ch_idx != '0)) begin
                        state_n  = HUNT;
                        ch_idx_n = '0;
                        err_n    = 1'b1;
                    end else if (is_pos) begin
                        // Header may be starting on a frame boundary: keep lock while it is checked.
                        state_n    = SYNC1;
                        sync_cnt_n = SC_W'(1);
                        relock_n   = 1'b1;
                    end else if (ch_idx == LAST_IDX) begin
                        emit     = 1'b1;
                        ch_idx_n = '0;
                        if (expire) begin
                            state_n = HUNT;
                            err_n   = 1'b1;
                        end
                    end else begin
                        store    = 1'b1;
                        ch_idx_n = ch_idx + IDX_W'(1);
                    end
                end
                default: state_n = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= HUNT;
            sync_cnt  <= '0;
            ch_idx    <= '0;
            relock    <= 1'b0;
            out_valid <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_n;
            sync_cnt  <= sync_cnt_n;
            ch_idx    <= ch_idx_n;
            relock    <= relock_n;
            out_valid <= emit;
            frame_err <= err_n;
        end
    end

    for (genvar i = 0; i < NUM_CH - 1; i++) begin : g_slot
        logic [DATA_W-1:0] word;
        always_ff @(posedge clk) begin
            if (reset) begin
                word <= '0;
            end else if (store && ch_idx == IDX_W'(i)) begin
                word <= in_data;
            end
        end
        assign frame_buf[i*DATA_W +: DATA_W] = word;
    end

    // The last channel word goes straight to the output alongside the stored ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_data <= '0;
        end else if (emit) begin
            out_data <= {in_data, frame_buf};
        end
    end

    assign locked = (state == LOCKED) || (relock && (state == SYNC1 || state == SYNC2));

    syn_frame_timer #(
        .MAX_FRAMES (MAX_FRAMES)
    ) u_frame_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (timer_clear),
        .tick   (emit),
        .expire (expire)
    );

`ifdef SYN_ERR_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            err_cnt <= '0;
        end else if (err_n && err_cnt != 16'hFFFF) begin
            err_cnt <= err_cnt + 16'd1;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_syn_deframer.sv
//==============================================================================
// tb_syn_deframer : scoreboard bench for syn_deframer (MAX_FRAMES reduced to 4).
// Revision : 1.0
//==============================================================================
`default_nettype none

module tb_syn_deframer;
    import syn_pkg::*;

    localparam int DATA_W     = 24;
    localparam int NUM_CH     = 8;
    localparam int MAX_FRAMES = 4;
    localparam int FW         = NUM_CH * DATA_W;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic [FW-1:0]     out_data;
    logic              out_valid;
    logic              locked;
    logic              frame_err;
`ifdef SYN_ERR_CNT_EN
    logic [15:0]       err_cnt;
`endif

    always #5 clk = ~clk;

    syn_deframer #(
        .DATA_W     (DATA_W),
        .NUM_CH     (NUM_CH),
        .MAX_FRAMES (MAX_FRAMES)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .locked    (locked),
        .frame_err (frame_err)
`ifdef SYN_ERR_CNT_EN
        ,
        .err_cnt   (err_cnt)
`endif
    );

    int checks   = 0;
    int errors   = 0;
    int ov_seen  = 0;
    int err_seen = 0;
    int e0;
    logic [FW-1:0] exp_q[$];
    logic [FW-1:0] fr;

    task automatic check_value(input string tag, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (out_valid) begin
            ov_seen++;
            if (exp_q.size() == 0) check_value("spurious_out_valid", 1, 0);
            else                   check_value("out_data", out_data, exp_q.pop_front());
        end
        if (frame_err) err_seen++;
    end

    task automatic send(input logic [DATA_W-1:0] w);
        in_valid = 1'b1;
        in_data  = w;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_header();
        repeat (NUM_CH) send(DATA_W'(SYNC_POS));
        repeat (NUM_CH) send(DATA_W'(SYNC_NEG));
    endtask

    function automatic logic [FW-1:0] make_frame(input int base);
        logic [FW-1:0] f;
        for (int k = 0; k < NUM_CH; k++) f[k*DATA_W +: DATA_W] = DATA_W'(base + k + 1);
        return f;
    endfunction

    task automatic send_frame(input logic [FW-1:0] f, input bit expect_emit);
        if (expect_emit) exp_q.push_back(f);
        for (int k = 0; k < NUM_CH; k++) begin
            send(f[k*DATA_W +: DATA_W]);
            check_value("out_valid_timing", out_valid, (expect_emit && k == NUM_CH - 1));
        end
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        check_value("rst_out_data", out_data, 0);
        check_value("rst_out_valid", out_valid, 0);
        check_value("rst_locked", locked, 0);
        check_value("rst_frame_err", frame_err, 0);
        reset = 1'b0;

        // Basic lock and first frame
        repeat (NUM_CH) send(DATA_W'(SYNC_POS));
        repeat (NUM_CH - 1) send(DATA_W'(SYNC_NEG));
        check_value("locked_before_16", locked, 0);
        send(DATA_W'(SYNC_NEG));
        check_value("locked_after_16", locked, 1);
        send_frame(make_frame(0), 1'b1);
        idle(3);
        check_value("out_valid_idle", out_valid, 0);
        check_value("out_data_hold", out_data, make_frame(0));

        // Escaped words are ordinary data
        fr = make_frame(32'h100);
        fr[0 +: DATA_W]        = DATA_W'(ESC_POS);
        fr[3*DATA_W +: DATA_W] = DATA_W'(ESC_NEG);
        send_frame(fr, 1'b1);
        check_value("locked_escape", locked, 1);

        // Repeat header with idle gaps keeps lock
        repeat (NUM_CH) begin
            send(DATA_W'(SYNC_POS));
            idle(2);
            check_value("relock_pos_locked", locked, 1);
        end
        repeat (NUM_CH) begin
            send(DATA_W'(SYNC_NEG));
            idle(1);
            check_value("relock_neg_locked", locked, 1);
        end
        send_frame(make_frame(32'h200), 1'b1);

        // SYNC_NEG at ch_idx 3 breaks alignment
        e0 = err_seen;
        send(24'h000301);
        send(24'h000302);
        send(24'h000303);
        send(DATA_W'(SYNC_NEG));
        check_value("neg_mid_frame_err", frame_err, 1);
        check_value("neg_mid_locked", locked, 0);
        idle(3);
        check_value("neg_mid_err_once", err_seen - e0, 1);

        // Short header is rejected
        repeat (NUM_CH - 1) send(DATA_W'(SYNC_POS));
        send(DATA_W'(SYNC_NEG));
        check_value("short_hdr_locked", locked, 0);
        send_frame(make_frame(32'h400), 1'b0);

        // Frame timeout after MAX_FRAMES frames
        send_header();
        e0 = err_seen;
        repeat (MAX_FRAMES - 1) send_frame(make_frame(32'h500), 1'b1);
        check_value("timeout_not_yet", locked, 1);
        send_frame(make_frame(32'h600), 1'b1);
        check_value("timeout_frame_err", frame_err, 1);
        check_value("timeout_locked", locked, 0);
        idle(2);
        check_value("timeout_err_once", err_seen - e0, 1);

        // Failed relock drops lock
        send_header();
        send_frame(make_frame(32'h700), 1'b1);
        repeat (3) send(DATA_W'(SYNC_POS));
        check_value("relock_hold", locked, 1);
        send(24'h000055);
        check_value("relock_fail_err", frame_err, 1);
        check_value("relock_fail_locked", locked, 0);
        idle(2);
        check_value("err_total", err_seen, 3);
`ifdef SYN_ERR_CNT_EN
        check_value("err_cnt_total", err_cnt, 3);
`endif

        // Reset during word 5 of a frame
        send_header();
        for (int k = 0; k < 4; k++) send(DATA_W'(32'h800 + k));
        in_valid = 1'b1;
        in_data  = 24'h000805;
        reset    = 1'b1;
        @(posedge clk);
        #1;
        reset    = 1'b0;
        in_valid = 1'b0;
        check_value("midrst_out_data", out_data, 0);
        check_value("midrst_out_valid", out_valid, 0);
        check_value("midrst_locked", locked, 0);
        check_value("midrst_frame_err", frame_err, 0);
`ifdef SYN_ERR_CNT_EN
        check_value("midrst_err_cnt", err_cnt, 0);
`endif
        for (int k = 5; k < NUM_CH; k++) begin
            send(DATA_W'(32'h800 + k));
            check_value("post_rst_no_valid", out_valid, 0);
        end
        check_value("post_rst_locked", locked, 0);
        idle(2);

        check_value("queue_drained", exp_q.size(), 0);
        check_value("frames_emitted", ov_seen, 8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/syn_deframer.md
SYN_DEFRAMER -- requirements
Module: syn_deframer

Interface
REQ-001 Parameter DATA_W, 24, channel word width.
REQ-002 Parameter NUM_CH, 8, channel words per sample frame.
REQ-003 Parameter MAX_FRAMES, 1024, maximum data frames allowed between sync headers while locked.
REQ-004 Port clk  input  1  sole clock; all logic on its rising edge.
REQ-005 Port reset  input  1  synchronous, active-high reset.
REQ-006 Port in_valid  input  1  qualifies in_data for one cycle; no backpressure.
REQ-007 Port in_data  input  DATA_W  serial channel word, CH1 first.
REQ-008 Port out_data  output  NUM_CH*DATA_W  deframed sample; CH1 in the LSBs.
REQ-009 Port out_valid  output  1  one-cycle pulse when out_data updates.
REQ-010 Port locked  output  1  high while frame alignment is valid.
REQ-011 Port frame_err  output  1  one-cycle pulse on an alignment loss.

Function
REQ-012 The sync words SHALL be SYNC_POS=24'h7FFFFF and SYNC_NEG=24'h800000.
REQ-013 A header SHALL be NUM_CH consecutive valid SYNC_POS words followed by NUM_CH consecutive valid SYNC_NEG words.
REQ-014 The states SHALL be HUNT, SYNC1, SYNC2 and LOCKED.
REQ-015 Words are consumed only when in_valid=1; idle cycles SHALL change no state, counter or output.
REQ-016 HUNT: on SYNC_POS, go to SYNC1 with count=1; on any other word, stay in HUNT.
REQ-017 SYNC1: after the NUM_CH-th SYNC_POS, go to SYNC2 with count=0; any other word goes to HUNT with count=0.
REQ-018 SYNC2: after the NUM_CH-th SYNC_NEG, go to LOCKED with ch_idx=0 and frame counter=0; SYNC_POS goes to SYNC1 with count=1; any other word goes to HUNT.
REQ-019 LOCKED: store each word into slot ch_idx, then increment ch_idx; ch_idx wraps NUM_CH-1 to 0.
REQ-020 On acceptance of slot NUM_CH-1, out_data SHALL be updated and out_valid SHALL pulse on the next cycle (latency 1 clock).
REQ-021 Between updates, out_data SHALL hold its value.
REQ-022 LOCKED with SYNC_POS at ch_idx=0: go to SYNC1 with count=1 and a relock flag set; locked stays 1.
REQ-023 If a header entered with relock set fails, locked drops and frame_err pulses.
REQ-024 LOCKED with SYNC_NEG at any index, or SYNC_POS at ch_idx≠0: pulse frame_err, discard the partial frame, go to HUNT, drop locked.
REQ-025 The frame counter SHALL increment per emitted frame; reaching MAX_FRAMES without a header pulses frame_err, goes to HUNT and drops locked.
REQ-026 Escaped words 24'h7FFFFE and 24'h800001 SHALL pass through unchanged as data.
REQ-027 locked SHALL be 1 in LOCKED, and in SYNC1/SYNC2 when relock is set; otherwise 0.

Reset
REQ-028 Reset SHALL dominate in_valid.
REQ-029 Reset SHALL force HUNT, clear all counters, relock and ch_idx, and drive out_data=0, out_valid=0, locked=0, frame_err=0.
REQ-030 Reset mid-frame SHALL discard partial words, with no out_valid pulse.

Configuration
REQ-031 Macro SYN_ERR_CNT_EN: when defined, add output err_cnt (16 bits), a saturating count of frame_err pulses, cleared by reset.
REQ-032 Without SYN_ERR_CNT_EN, the err_cnt port and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-033 Shared package syn_pkg SHALL hold SYNC_POS, SYNC_NEG, the escape constants and the state typedef; the frame-side inserter uses the same package.
REQ-034 The MAX_FRAMES counter and its timeout compare SHALL be one sub-module, syn_frame_timer.

Verification
REQ-035 Send 8x7FFFFF, 8x800000, then words 1..8: locked=1 after the 16th word; out_valid one cycle after word 8; out_data CH1=1 … CH8=8.
REQ-036 Send 7x7FFFFF then 800000: state returns to HUNT, locked=0, no out_valid.
REQ-037 While locked, send 800000 at ch_idx=3: frame_err pulses once, locked=0, no out_valid for that frame.
REQ-038 With MAX_FRAMES=4, send a header then 4 data frames with no header: frame_err pulses after the 4th frame and locked=0.
REQ-039 While locked, send a repeat header with gaps of in_valid=0: locked stays 1 throughout and the following data frame is emitted.
REQ-040 Assert reset during word 5 of a frame: all outputs are 0 next cycle; with SYN_ERR_CNT_EN defined, err_cnt=0.
